// File: rtl/keypad_scan_ctrl_pkg.sv
// Shared state encoding and sizing helpers for the keypad scanner and its event queue.
package keypad_scan_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_SCAN = 2'd0,
      ST_DEB  = 2'd1,
      ST_HELD = 2'd2
   } scan_state_e;

   // Key code width: enough bits for row*COLS+col.
   function automatic int kw_f(input int rows, input int cols);
      return $clog2(rows * cols);
   endfunction

   // Counter width for values 0..n-1, never narrower than one bit.
   function automatic int cnt_w_f(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/key_fifo.sv
// First-word-fall-through event queue: a write is visible on rd_dat one cycle later.
// wr_rdy drops only when full with no pop this cycle; a pop on an empty queue is ignored.
module key_fifo
   import keypad_scan_ctrl_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int DEPTH = 4
) (
   input  logic             fin,
   input  logic             rst_n,
   input  logic             wr_vld,
   output logic             wr_rdy,
   input  logic [WIDTH-1:0] wr_dat,
   output logic             rd_vld,
   input  logic             rd_rdy,
   output logic [WIDTH-1:0] rd_dat
);

   localparam int AW = cnt_w_f(DEPTH);

   logic [AW:0]      wp_q, wp_d;
   logic [AW:0]      rp_q, rp_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic             empty, full, push, pop;

   // Extra pointer bit separates the full and empty cases when the indices match.
   assign empty  = (wp_q == rp_q);
   assign full   = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
   assign pop    = rd_rdy && !empty;
   assign wr_rdy = !full || rd_rdy;
   assign push   = wr_vld && wr_rdy;
   assign rd_vld = !empty;
   assign rd_dat = mem_q[rp_q[AW-1:0]];

   always_comb begin
      mem_d = mem_q;
      wp_d  = wp_q;
      rp_d  = rp_q;
      if (push) begin
         mem_d[wp_q[AW-1:0]] = wr_dat;
         wp_d                = wp_q + (AW+1)'(1);
      end
      if (pop) begin
         rp_d = rp_q + (AW+1)'(1);
      end
   end

   always_ff @(posedge fin or negedge rst_n) begin
      if (!rst_n) begin
         wp_q <= '0;
         rp_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         wp_q  <= wp_d;
         rp_q  <= rp_d;
         mem_q <= mem_d;
      end
   end

endmodule

// File: rtl/keypad_scan_ctrl.sv
// Matrix keypad scanner: divided scan tick, one-hot rows, debounced single-key press/release detection.
// Press pushed to the queue in the press_pls cycle (key_valid one cycle later); a full queue drops it and sets overflow.
module keypad_scan_ctrl
   import keypad_scan_ctrl_pkg::*;
#(
   parameter int  ROWS     = 4,
   parameter int  COLS     = 3,
   parameter int  DIV      = 8000,
   parameter int  DB_TICKS = 3,
   parameter int  DEPTH    = 4,
   localparam int KW       = kw_f(ROWS, COLS)
) (
   input  logic            fin,
   input  logic            rst_n,
   input  logic [COLS-1:0] colum,
   output logic [ROWS-1:0] scan,
   output logic [KW-1:0]   key_code,
   output logic            key_valid,
   input  logic            key_ready,
   output logic            pressed,
   output logic            press_pls,
   output logic            overflow
);

   localparam int DVW = cnt_w_f(DIV);
   localparam int RW  = cnt_w_f(ROWS);
   localparam int CIW = cnt_w_f(COLS);
   localparam int CW  = cnt_w_f(DB_TICKS + 1);

   logic [COLS-1:0] col_s1_q, col_s1_d;
   logic [COLS-1:0] col_s2_q, col_s2_d;
   logic [DVW-1:0]  div_q, div_d;
   scan_state_e     state_q, state_d;
   logic [RW-1:0]   row_q, row_d;
   logic [ROWS-1:0] scan_q, scan_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [COLS-1:0] lat_pat_q, lat_pat_d;
   logic [CIW-1:0]  lat_col_q, lat_col_d;
   logic            pressed_q, pressed_d;
   logic            press_pls_q, press_pls_d;
   logic [KW-1:0]   code_q, code_d;
   logic            overflow_q, overflow_d;

   logic            tick;
   logic [RW-1:0]   row_nxt;
   logic [CIW-1:0]  hit_col;
   logic [CIW-1:0]  acc_col;
   logic            accept;
   logic            push_rdy;

   assign tick    = (div_q == DVW'(DIV - 1));
   assign row_nxt = (row_q == RW'(ROWS - 1)) ? '0 : row_q + RW'(1);

   always_comb begin
      hit_col = '0;
      for (int c = 0; c < COLS; c++) begin
         if (col_s2_q[c]) hit_col = CIW'(c);
      end
   end

   always_comb begin
      col_s1_d    = colum;
      col_s2_d    = col_s1_q;
      div_d       = tick ? '0 : div_q + DVW'(1);
      state_d     = state_q;
      row_d       = row_q;
      cnt_d       = cnt_q;
      lat_pat_d   = lat_pat_q;
      lat_col_d   = lat_col_q;
      pressed_d   = pressed_q;
      press_pls_d = 1'b0;
      code_d      = code_q;
      accept      = 1'b0;
      acc_col     = lat_col_q;

      if (tick) begin
         case (state_q)
            ST_SCAN: begin
               // Zero or several columns (chord/ghost) both count as no key here.
               if ($countones(col_s2_q) == 1) begin
                  lat_pat_d = col_s2_q;
                  lat_col_d = hit_col;
                  acc_col   = hit_col;
                  cnt_d     = CW'(1);
                  if (DB_TICKS == 1) accept = 1'b1;
                  else               state_d = ST_DEB;
               end else begin
                  row_d = row_nxt;
               end
            end
            ST_DEB: begin
               if (col_s2_q == lat_pat_q) begin
                  if (int'(cnt_q) + 1 >= DB_TICKS) accept = 1'b1;
                  else                             cnt_d  = cnt_q + CW'(1);
               end else begin
                  state_d = ST_SCAN;
               end
            end
            ST_HELD: begin
               if (col_s2_q == '0) begin
                  if (int'(cnt_q) + 1 >= DB_TICKS) begin
                     pressed_d = 1'b0;
                     state_d   = ST_SCAN;
                     row_d     = row_nxt;
                     cnt_d     = '0;
                  end else begin
                     cnt_d = cnt_q + CW'(1);
                  end
               end else begin
                  cnt_d = '0;
               end
            end
            default: state_d = ST_SCAN;
         endcase
      end

      if (accept) begin
         state_d     = ST_HELD;
         cnt_d       = '0;
         pressed_d   = 1'b1;
         press_pls_d = 1'b1;
         code_d      = KW'(int'(row_q) * COLS + int'(acc_col));
      end

      scan_d     = ROWS'(1) << row_d;
      // The push happens while press_pls_q is high; a refused push is a lost key.
      overflow_d = overflow_q | (press_pls_q & ~push_rdy);
   end

   always_ff @(posedge fin or negedge rst_n) begin
      if (!rst_n) begin
         col_s1_q    <= '0;
         col_s2_q    <= '0;
         div_q       <= '0;
         state_q     <= ST_SCAN;
         row_q       <= '0;
         scan_q      <= ROWS'(1);
         cnt_q       <= '0;
         lat_pat_q   <= '0;
         lat_col_q   <= '0;
         pressed_q   <= 1'b0;
         press_pls_q <= 1'b0;
         code_q      <= '0;
         overflow_q  <= 1'b0;
      end else begin
         col_s1_q    <= col_s1_d;
         col_s2_q    <= col_s2_d;
         div_q       <= div_d;
         state_q     <= state_d;
         row_q       <= row_d;
         scan_q      <= scan_d;
         cnt_q       <= cnt_d;
         lat_pat_q   <= lat_pat_d;
         lat_col_q   <= lat_col_d;
         pressed_q   <= pressed_d;
         press_pls_q <= press_pls_d;
         code_q      <= code_d;
         overflow_q  <= overflow_d;
      end
   end

   key_fifo #(
      .WIDTH (KW),
      .DEPTH (DEPTH)
   ) u_key_fifo (
      .fin    (fin),
      .rst_n  (rst_n),
      .wr_vld (press_pls_q),
      .wr_rdy (push_rdy),
      .wr_dat (code_q),
      .rd_vld (key_valid),
      .rd_rdy (key_ready),
      .rd_dat (key_code)
   );

   assign scan      = scan_q;
   assign pressed   = pressed_q;
   assign press_pls = press_pls_q;
   assign overflow  = overflow_q;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Keypad scanner bench: physical key-matrix model drives colum, scoreboard checks popped key codes.
module tb_keypad_scan_ctrl;

   localparam int ROWS  = 4;
   localparam int COLS  = 3;
   localparam int DIV   = 4;
   localparam int DBT   = 3;
   localparam int DEPTH = 4;
   localparam int KW    = $clog2(ROWS * COLS);

   logic            fin = 1'b0;
   logic            rst_n;
   logic [COLS-1:0] colum;
   logic [ROWS-1:0] scan;
   logic [KW-1:0]   key_code;
   logic            key_valid;
   logic            key_ready;
   logic            pressed;
   logic            press_pls;
   logic            overflow;

   logic [ROWS-1:0][COLS-1:0] held;
   int   exp_q[$];
   logic exp_ovf;
   int   exp_events = 0;
   int   pls_cnt    = 0;
   int   rdy_mode   = 0;
   int   n_chk      = 0;
   int   n_err      = 0;

   keypad_scan_ctrl #(
      .ROWS(ROWS), .COLS(COLS), .DIV(DIV), .DB_TICKS(DBT), .DEPTH(DEPTH)
   ) dut (
      .fin(fin), .rst_n(rst_n), .colum(colum), .scan(scan), .key_code(key_code),
      .key_valid(key_valid), .key_ready(key_ready), .pressed(pressed),
      .press_pls(press_pls), .overflow(overflow)
   );

   always #5 fin = ~fin;

   task automatic chk(input string name, input longint act, input longint exp);
      n_chk++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // A pressed switch connects its row drive to its column line.
   function automatic logic [COLS-1:0] phys(input logic [ROWS-1:0] s,
                                            input logic [ROWS-1:0][COLS-1:0] h);
      logic [COLS-1:0] v;
      v = '0;
      for (int r = 0; r < ROWS; r++) if (s[r]) v |= h[r];
      return v;
   endfunction

   initial begin
      colum = '0;
      forever begin
         @(posedge fin);
         #1;
         colum = phys(scan, held);
      end
   end

   initial begin
      key_ready = 1'b1;
      forever begin
         @(posedge fin);
         #1;
         case (rdy_mode)
            0:       key_ready = 1'b1;
            1:       key_ready = ($urandom_range(0, 3) != 0);
            default: key_ready = 1'b0;
         endcase
      end
   end

   // Monitor: compares every popped code against the scoreboard head.
   initial begin
      int e;
      forever begin
         @(negedge fin);
         if (rst_n) begin
            if (press_pls) pls_cnt++;
            if (key_valid && key_ready) begin
               if (exp_q.size() == 0) begin
                  n_chk++;
                  n_err++;
                  $display("FAIL spurious_key: got code %0d, expected no key", key_code);
               end else begin
                  e = exp_q.pop_front();
                  chk("key_code", key_code, e);
               end
            end
         end
      end
   end

   initial begin
      #600000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic ticks(input int n);
      repeat (n * DIV) @(negedge fin);
   endtask

   // Model: every clean press yields row*COLS+col, dropped if DEPTH codes are already waiting.
   task automatic expect_press(input int r, input int c);
      exp_events++;
      if (exp_q.size() >= DEPTH) exp_ovf = 1'b1;
      else                       exp_q.push_back(r * COLS + c);
   endtask

   task automatic do_press(input int r, input int c, input int extra, input int gap);
      int w;
      expect_press(r, c);
      held[r][c] = 1'b1;
      w = 0;
      while (!pressed && w < 200) begin @(negedge fin); w++; end
      chk("pressed_rise", pressed, 1);
      ticks(extra);
      held[r][c] = 1'b0;
      w = 0;
      while (pressed && w < 200) begin @(negedge fin); w++; end
      chk("pressed_fall", pressed, 0);
      ticks(gap);
   endtask

   task automatic enter_reset();
      rst_n   = 1'b0;
      exp_q.delete();
      exp_ovf = 1'b0;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_scan"}, scan, 1);
      chk({tag, "_key_valid"}, key_valid, 0);
      chk({tag, "_pressed"}, pressed, 0);
      chk({tag, "_press_pls"}, press_pls, 0);
      chk({tag, "_overflow"}, overflow, 0);
   endtask

   initial begin
      int w;
      int p0;
      int changes;
      int r, c;
      logic [ROWS-1:0] prev;

      held    = '0;
      exp_ovf = 1'b0;
      rst_n   = 1'b0;
      repeat (3) @(negedge fin);
      chk_reset_outputs("rst");
      rst_n = 1'b1;

      // Idle scan: one row step every DIV cycles.
      for (int k = 1; k <= 16; k++) begin
         @(negedge fin);
         chk("scan_seq", scan, 1 << ((k / DIV) % ROWS));
      end
      chk("idle_no_key", key_valid, 0);

      // Single key row 2 / col 1 and release timing.
      p0 = pls_cnt;
      expect_press(2, 1);
      held[2][1] = 1'b1;
      w = 0;
      while (!pressed && w < 200) begin @(negedge fin); w++; end
      chk("s2_pressed", pressed, 1);
      ticks(2);
      held[2][1] = 1'b0;
      repeat (11) @(negedge fin);
      chk("s2_still_held", pressed, 1);
      repeat (5) @(negedge fin);
      chk("s2_released", pressed, 0);
      ticks(2);
      chk("s2_one_pulse", pls_cnt - p0, 1);

      // Bounce: single-tick contacts never accumulate enough stable samples.
      p0 = pls_cnt;
      for (int i = 0; i < 3; i++) begin
         held[1][0] = 1'b1;
         ticks(1);
         held[1][0] = 1'b0;
         ticks(1);
      end
      chk("bounce_quiet", pls_cnt - p0, 0);
      do_press(1, 0, 1, 2);
      chk("bounce_one_event", pls_cnt - p0, 1);

      // Chord on every row: ignored, scan keeps stepping.
      p0 = pls_cnt;
      for (int i = 0; i < ROWS; i++) held[i] = 3'b011;
      changes = 0;
      prev = scan;
      for (int k = 0; k < 8 * DIV; k++) begin
         @(negedge fin);
         if (scan != prev) changes++;
         prev = scan;
      end
      chk("chord_scan_steps", changes, 8);
      chk("chord_no_pulse", pls_cnt - p0, 0);
      chk("chord_no_key", key_valid, 0);
      held = '0;
      ticks(3);

      // Randomized presses with optional sub-tick glitches.
      rdy_mode = 1;
      for (int i = 0; i < 12; i++) begin
         if ($urandom_range(0, 1) == 1) begin
            r = $urandom_range(0, ROWS - 1);
            c = $urandom_range(0, COLS - 1);
            held[r][c] = 1'b1;
            repeat ($urandom_range(1, 3)) @(negedge fin);
            held[r][c] = 1'b0;
            ticks(3);
         end
         r = $urandom_range(0, ROWS - 1);
         c = $urandom_range(0, COLS - 1);
         do_press(r, c, $urandom_range(0, 4), $urandom_range(1, 4));
      end
      rdy_mode = 0;
      w = 0;
      while (exp_q.size() != 0 && w < 100) begin @(negedge fin); w++; end
      chk("rand_drained", exp_q.size(), 0);

      // Overflow: consumer stalled, five presses into a four-deep queue.
      rdy_mode = 2;
      repeat (3) @(negedge fin);
      do_press(0, 0, 1, 2);
      do_press(1, 1, 1, 2);
      do_press(2, 2, 1, 2);
      do_press(3, 2, 1, 2);
      do_press(0, 1, 1, 2);
      chk("ovf_set", overflow, exp_ovf);
      chk("ovf_key_valid", key_valid, 1);
      rdy_mode = 0;
      w = 0;
      while (exp_q.size() != 0 && w < 100) begin @(negedge fin); w++; end
      chk("ovf_drained", exp_q.size(), 0);
      repeat (3) @(negedge fin);
      chk("ovf_empty", key_valid, 0);
      chk("ovf_sticky", overflow, exp_ovf);

      // Reset during debounce.
      held[3][1] = 1'b1;
      w = 0;
      while (scan != 4'b1000 && w < 100) begin @(negedge fin); w++; end
      chk("deb_row_reached", scan, 8);
      repeat (5) @(posedge fin);
      #2;
      enter_reset();
      #1;
      chk_reset_outputs("deb_rst");
      held[3][1] = 1'b0;
      repeat (3) @(negedge fin);
      rst_n = 1'b1;
      do_press(3, 1, 1, 2);

      // Reset while a key is held.
      expect_press(2, 0);
      held[2][0] = 1'b1;
      w = 0;
      while (!pressed && w < 200) begin @(negedge fin); w++; end
      chk("held_pressed", pressed, 1);
      repeat (6) @(negedge fin);
      chk("held_popped", exp_q.size(), 0);
      #1;
      enter_reset();
      #1;
      chk_reset_outputs("held_rst");
      held[2][0] = 1'b0;
      repeat (3) @(negedge fin);
      rst_n = 1'b1;
      do_press(2, 0, 1, 2);

      w = 0;
      while (exp_q.size() != 0 && w < 100) begin @(negedge fin); w++; end
      chk("final_queue_empty", exp_q.size(), 0);
      chk("final_pulse_total", pls_cnt, exp_events);
      chk("final_overflow", overflow, exp_ovf);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
